// File: rtl/acc_sched.sv
// Round-robin frame scheduler in front of a shared vector accumulator.
// Each granted frame clears the accumulator, streams beats in, then returns the captured sum.
module acc_sched #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ID_W       = $clog2(NREQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ-1:0]            req_last_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic                       acc_clear_o,
  output logic                       acc_valid_o,
  output logic [DATA_WIDTH-1:0]      acc_data_o,
  input  logic                       acc_valid_i,
  input  logic [DATA_WIDTH-1:0]      acc_data_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [DATA_WIDTH-1:0]      res_data_o,
  output logic [ID_W-1:0]            res_id_o,
  output logic [LEN_W-1:0]           res_beats_o,
  output logic                       busy_o,
  output logic                       err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ID_W-1:0]       r_gnt;
  logic [ID_W-1:0]       r_ptr;
  logic [LEN_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [ID_W-1:0]       r_res_id;
  logic [LEN_W-1:0]      r_res_beats;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] w_slice [NREQ];
  logic [NREQ-1:0]       w_rot;
  logic                  w_pick_ok;
  int unsigned           w_pick_idx;
  int unsigned           w_pick_sum;
  logic [ID_W-1:0]       w_pick;
  logic                  w_beat;

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign w_slice[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign w_rot = (req_valid_i >> r_ptr) | (req_valid_i << (NREQ - 32'(r_ptr)));

  always_comb begin
    w_pick_ok  = 1'b0;
    w_pick_idx = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_pick_ok  = 1'b1;
        w_pick_idx = 32'(i);
      end
    end
    w_pick_sum = 32'(r_ptr) + w_pick_idx;
    if (w_pick_sum >= NREQ) begin
      w_pick_sum = w_pick_sum - NREQ;
    end
    w_pick = ID_W'(w_pick_sum);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    req_ready_o = '0;
    acc_clear_o = 1'b0;
    acc_valid_o = 1'b0;
    acc_data_o  = '0;
    res_valid_o = 1'b0;
    busy_o      = 1'b1;
    w_beat      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_pick_ok) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clear_o = 1'b1;
        w_next      = S_STREAM;
      end
      S_STREAM: begin
        req_ready_o[r_gnt] = 1'b1;
        acc_data_o         = w_slice[r_gnt];
        w_beat             = req_valid_i[r_gnt];
        acc_valid_o        = w_beat;
        if (w_beat && req_last_i[r_gnt]) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next = S_RESULT;
      end
      S_RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Grant, beat counter, result capture, pointer and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_beats <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_pick_ok) begin
        r_gnt <= w_pick;
        r_cnt <= '0;
      end
      if (w_beat && r_cnt != '1) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
      if (r_state == S_DRAIN) begin
        r_res_data  <= acc_data_i;
        r_res_id    <= r_gnt;
        r_res_beats <= r_cnt;
        if (!acc_valid_i) begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_RESULT && res_ready_i) begin
        r_ptr <= (r_gnt == ID_W'(NREQ - 1)) ? '0 : r_gnt + ID_W'(1);
      end
    end
  end

  assign res_data_o  = r_res_data;
  assign res_id_o    = r_res_id;
  assign res_beats_o = r_res_beats;
  assign err_o       = r_err;

endmodule

// File: tb/tb_acc_sched.sv
// Bench for acc_sched: queued requester frames, a stub accumulator, and a
// round-robin result model built from per-requester frame sums.
module tb_acc_sched;
  localparam int unsigned DW = 512;
  localparam int unsigned NR = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned IW = 2;

  logic              clk;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_last_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR-1:0]     req_ready_o;
  logic              acc_clear_o;
  logic              acc_valid_o;
  logic [DW-1:0]     acc_data_o;
  logic              acc_valid_i;
  logic [DW-1:0]     acc_data_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DW-1:0]     res_data_o;
  logic [IW-1:0]     res_id_o;
  logic [LW-1:0]     res_beats_o;
  logic              busy_o;
  logic              err_o;

  acc_sched #(.DATA_WIDTH(DW), .NREQ(NR), .LEN_W(LW), .ID_W(IW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .acc_clear_o(acc_clear_o), .acc_valid_o(acc_valid_o), .acc_data_o(acc_data_o),
    .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_id_o(res_id_o), .res_beats_o(res_beats_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub accumulator: clear to zero, add on valid, never reset.
  logic [DW-1:0] acc_sum = '0;
  logic          acc_ok  = 1'b1;
  always @(posedge clk) begin
    if (acc_clear_o) acc_sum <= '0;
    else if (acc_valid_o) acc_sum <= acc_sum + acc_data_o;
  end
  assign acc_data_i  = acc_sum;
  assign acc_valid_i = acc_ok;

  typedef struct { bit v; bit last; logic [DW-1:0] d; } beat_t;
  typedef struct { logic [DW-1:0] sum; logic [LW-1:0] n; int id; } res_t;

  beat_t         dq [NR][$];
  res_t          fq [NR][$];
  res_t          expq [$];
  logic [DW-1:0] cur_sum [NR];
  int            cur_cnt [NR];
  int            m_ptr;
  bit            rnd_ready;
  int            total;
  int            bad;

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic push_beat(input int k, input bit v, input bit last, input logic [DW-1:0] d);
    beat_t b;
    res_t  r;
    b.v = v; b.last = last; b.d = d;
    dq[k].push_back(b);
    if (v) begin
      cur_sum[k] = cur_sum[k] + d;
      cur_cnt[k]++;
      if (last) begin
        r.sum = cur_sum[k];
        r.n   = (cur_cnt[k] > 255) ? LW'(255) : LW'(cur_cnt[k]);
        r.id  = k;
        fq[k].push_back(r);
        cur_sum[k] = '0;
        cur_cnt[k] = 0;
      end
    end
  endtask

  task automatic add_rand_frame(input int k, input int n, input int bub_pct);
    for (int b = 0; b < n; b++) begin
      if (b > 0 && $urandom_range(0, 99) < bub_pct) push_beat(k, 1'b0, 1'b0, rnd_word());
      push_beat(k, 1'b1, b == n - 1, rnd_word());
    end
  endtask

  // Round-robin service order over all pending frames.
  task automatic build_expected();
    bit any;
    do begin
      any = 0;
      for (int i = 0; i < int'(NR); i++) begin
        int k;
        k = (m_ptr + i) % NR;
        if (fq[k].size() > 0) begin
          expq.push_back(fq[k].pop_front());
          m_ptr = (k + 1) % NR;
          any = 1;
          break;
        end
      end
    end while (any);
  endtask

  task automatic drive_idle();
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    res_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < int'(NR); k++) begin
      dq[k].delete(); fq[k].delete(); cur_sum[k] = '0; cur_cnt[k] = 0;
    end
    expq.delete();
  endtask

  // Cycle engine: drives queued beats, checks ready/acc outputs and results.
  task automatic run_frames(input int stall, output int t_clear, output int t_res);
    int            stall_left;
    bit            done;
    bit            chk_idle;
    bit            snap_ok;
    logic [DW-1:0] s_data;
    logic [IW-1:0] s_id;
    logic [LW-1:0] s_beats;
    build_expected();
    t_clear = -1; t_res = -1; stall_left = stall; done = 0; chk_idle = 0; snap_ok = 0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      for (int k = 0; k < int'(NR); k++) begin
        if (dq[k].size() > 0) begin
          req_valid_i[k] = dq[k][0].v;
          req_last_i[k]  = dq[k][0].last;
          req_data_i[k*DW +: DW] = dq[k][0].d;
        end else begin
          req_valid_i[k] = 1'b0; req_last_i[k] = 1'b0; req_data_i[k*DW +: DW] = '0;
        end
      end
      if (res_valid_o && stall_left > 0) begin
        res_ready_i = 1'b0;
        stall_left--;
      end else begin
        res_ready_i = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      if (chk_idle) begin
        total++;
        if (busy_o !== 1'b0) begin
          bad++; $display("FAIL idle_after_release busy_o=%0b want 0", busy_o);
        end
        chk_idle = 0;
      end
      total++;
      if ($countones(req_ready_o) > 1) begin
        bad++; $display("FAIL ready_onehot req_ready_o=%b want at most one bit", req_ready_o);
      end
      if (req_ready_o == '0) begin
        total++;
        if (acc_valid_o !== 1'b0) begin
          bad++; $display("FAIL acc_valid_idle acc_valid_o=%0b want 0", acc_valid_o);
        end
      end
      for (int k = 0; k < int'(NR); k++) begin
        if (req_ready_o[k]) begin
          bit ev;
          ev = (dq[k].size() > 0) && dq[k][0].v;
          total++;
          if (acc_valid_o !== ev || (ev && acc_data_o !== dq[k][0].d)) begin
            bad++; $display("FAIL acc_drive req%0d acc_valid_o=%0b want %0b", k, acc_valid_o, ev);
          end
        end
      end
      if (acc_clear_o && t_clear < 0) t_clear = t;
      if (res_valid_o && t_res < 0) t_res = t;
      if (res_valid_o && !res_ready_i && stall > 0) begin
        if (!snap_ok) begin
          s_data = res_data_o; s_id = res_id_o; s_beats = res_beats_o; snap_ok = 1;
        end else begin
          total++;
          if (res_data_o !== s_data || res_id_o !== s_id || res_beats_o !== s_beats ||
              req_ready_o !== '0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL stall_hold id=%0d beats=%0d ready=%b busy=%0b want id=%0d beats=%0d ready=0 busy=1",
                            res_id_o, res_beats_o, req_ready_o, busy_o, s_id, s_beats);
          end
        end
      end
      if (res_valid_o && res_ready_i) begin
        res_t e;
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL result_extra id=%0d want no result", res_id_o);
        end else begin
          e = expq.pop_front();
          if (res_data_o !== e.sum || int'(res_id_o) != e.id || res_beats_o !== e.n) begin
            bad++; $display("FAIL result id=%0d beats=%0d sum_lo=%h want id=%0d beats=%0d sum_lo=%h",
                            res_id_o, res_beats_o, res_data_o[63:0], e.id, e.n, e.sum[63:0]);
          end
        end
        if (snap_ok) chk_idle = 1;
      end
      for (int k = 0; k < int'(NR); k++)
        if (req_ready_o[k] && dq[k].size() > 0) void'(dq[k].pop_front());
      done = (expq.size() == 0) && !chk_idle;
      for (int k = 0; k < int'(NR); k++) if (dq[k].size() > 0) done = 0;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL run_timeout pending=%0d want 0", expq.size());
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle();
    rst_i = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready_o !== '0 || acc_clear_o !== 1'b0 || acc_valid_o !== 1'b0 || acc_data_o !== '0 ||
        res_valid_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl ready=%b clr=%0b av=%0b rv=%0b busy=%0b err=%0b want all 0",
                      req_ready_o, acc_clear_o, acc_valid_o, res_valid_o, busy_o, err_o);
    end
    total++;
    if (res_data_o !== '0 || res_id_o !== '0 || res_beats_o !== '0) begin
      bad++; $display("FAIL reset_res id=%0d beats=%0d want 0 0", res_id_o, res_beats_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    int tc, tr;
    do_reset();
    for (int i = 1; i <= 4; i++) push_beat(1, 1'b1, i == 4, DW'(i));
    rnd_ready = 0;
    run_frames(0, tc, tr);
    total++;
    if (tc != 1 || tr != 7) begin
      bad++; $display("FAIL single_timing clear=%0d res=%0d want 1 7", tc, tr);
    end
  endtask

  task automatic test_round_robin();
    int tc, tr;
    do_reset();
    for (int k = 0; k < int'(NR); k++) add_rand_frame(k, 2, 0);
    add_rand_frame(0, 2, 0);
    rnd_ready = 1;
    run_frames(0, tc, tr);
  endtask

  task automatic test_bubble();
    int tc, tr;
    do_reset();
    push_beat(0, 1'b1, 1'b0, DW'(5));
    push_beat(0, 1'b0, 1'b0, DW'(99));
    push_beat(0, 1'b0, 1'b0, DW'(98));
    push_beat(0, 1'b1, 1'b1, DW'(7));
    rnd_ready = 0;
    run_frames(0, tc, tr);
  endtask

  task automatic test_stall();
    int tc, tr;
    do_reset();
    add_rand_frame(2, 3, 0);
    add_rand_frame(3, 1, 0);
    rnd_ready = 0;
    run_frames(10, tc, tr);
  endtask

  task automatic test_wrap_sat();
    int tc, tr;
    logic [DW-1:0] ones;
    do_reset();
    ones = '1;
    push_beat(3, 1'b1, 1'b0, ones);
    push_beat(3, 1'b1, 1'b1, DW'(2));
    add_rand_frame(1, 300, 0);
    rnd_ready = 0;
    run_frames(0, tc, tr);
  endtask

  task automatic test_ptr_wrap();
    int tc, tr;
    do_reset();
    add_rand_frame(2, 1, 0);
    rnd_ready = 0;
    run_frames(0, tc, tr);
    add_rand_frame(2, 2, 0);
    add_rand_frame(0, 2, 0);
    run_frames(0, tc, tr);
  endtask

  task automatic test_abort();
    int tc, tr, nb;
    bit hit;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.v = 1; b.last = (i == 3); b.d = DW'(100 * (i + 1));
      dq[0].push_back(b);
    end
    nb = 0; hit = 0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      req_valid_i[0] = dq[0][0].v;
      req_last_i[0]  = dq[0][0].last;
      req_data_i[DW-1:0] = dq[0][0].d;
      #1;
      if (req_ready_o[0]) begin
        if (nb == 1) begin
          rst_i = 1'b1; hit = 1;
        end
        nb++;
        void'(dq[0].pop_front());
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    total++;
    if (!hit || req_ready_o !== '0 || acc_clear_o !== 1'b0 || acc_valid_o !== 1'b0 ||
        res_valid_o !== 1'b0 || busy_o !== 1'b0 || res_beats_o !== '0) begin
      bad++; $display("FAIL abort_reset hit=%0b ready=%b busy=%0b rv=%0b want hit=1 ready=0 busy=0 rv=0",
                      hit, req_ready_o, busy_o, res_valid_o);
    end
    rst_i = 1'b0;
    dq[0].delete();
    m_ptr = 0;
    add_rand_frame(0, 3, 0);
    rnd_ready = 0;
    run_frames(0, tc, tr);
  endtask

  task automatic test_err();
    int tc, tr;
    do_reset();
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL err_initial err_o=%0b want 0", err_o);
    end
    acc_ok = 1'b0;
    add_rand_frame(2, 2, 0);
    rnd_ready = 0;
    run_frames(0, tc, tr);
    acc_ok = 1'b1;
    total++;
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL err_set err_o=%0b want 1", err_o);
    end
    add_rand_frame(1, 2, 0);
    run_frames(0, tc, tr);
    total++;
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL err_sticky err_o=%0b want 1", err_o);
    end
    do_reset();
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL err_clear err_o=%0b want 0", err_o);
    end
  endtask

  task automatic test_random();
    int tc, tr;
    do_reset();
    for (int f = 0; f < 30; f++)
      add_rand_frame(int'($urandom_range(0, NR - 1)), int'($urandom_range(1, 6)), 25);
    rnd_ready = 1;
    run_frames(0, tc, tr);
  endtask

  initial begin
    total = 0; bad = 0; m_ptr = 0; rnd_ready = 0;
    rst_i = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_bubble();
    test_stall();
    test_wrap_sat();
    test_ptr_wrap();
    test_abort();
    test_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/acc_sched.md
# acc_sched

Round-robin frame scheduler that shares one 512-bit vector accumulator (clear / valid / data in, running sum out) between NREQ requesters. For each granted frame it clears the accumulator, streams the requester's beats into it, captures the final sum and returns it on a valid/ready result port tagged with the requester id and beat count. It sits directly in front of the accumulator and owns all of its control inputs.

## Interface

- DATA_WIDTH, 512, beat and sum width
- NREQ, 4, number of requesters (≥2)
- LEN_W, 8, width of beat counter
- ID_W, $clog2(NREQ), width of requester id

- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NREQ  per-requester beat valid
- req_last_i  in  NREQ  per-requester last-beat flag, qualified by valid
- req_data_i  in  NREQ*DATA_WIDTH  per-requester beat data, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  NREQ  per-requester ready; at most one bit high
- acc_clear_o  out  1  to accumulator clear input
- acc_valid_o  out  1  to accumulator data-valid input
- acc_data_o  out  DATA_WIDTH  to accumulator data input
- acc_valid_i  in  1  accumulator output valid
- acc_data_i  in  DATA_WIDTH  accumulator running sum
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- res_data_o  out  DATA_WIDTH  captured frame sum
- res_id_o  out  ID_W  requester that owned the frame
- res_beats_o  out  LEN_W  beats in frame, saturating
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  sticky: acc_valid_i low in DRAIN

## Operation

- States: IDLE, CLEAR, STREAM, DRAIN, RESULT.
- IDLE: if any req_valid_i is high, pick the grant g round-robin starting at pointer ptr (first set bit at or above ptr, wrapping), register g, clear the beat counter, go to CLEAR. Otherwise stay.
- CLEAR (1 cycle): acc_clear_o=1, go to STREAM.
- STREAM: req_ready_o[g]=1, all other ready bits 0.
  - Beat = req_valid_i[g] & ready.
  - acc_valid_o = beat.
  - acc_data_o = slice g of req_data_i (combinational); 0 outside STREAM.
  - Each beat increments the counter, which saturates at 2^LEN_W-1.
  - A beat with req_last_i[g] moves to DRAIN.
  - Valid low gives a bubble: ready stays high and no accumulator update occurs.
- DRAIN (1 cycle): capture res_data_o<=acc_data_i, res_id_o<=g, res_beats_o<=counter. If acc_valid_i=0, set err_o. Go to RESULT.
- RESULT: res_valid_o=1, and res_* hold stable until res_ready_i. On the handshake, set ptr<=(g+1) mod NREQ and go to IDLE.
- Sum arithmetic is done by the accumulator, modulo 2^DATA_WIDTH. This block never modifies the data.
- Requests from non-granted requesters are ignored (ready 0) until their turn. Requests arriving during a frame wait.
- err_o is cleared only by rst_i.

## Timing

- Reset values: state IDLE, ptr 0, req_ready_o 0, acc_clear_o 0, acc_valid_o 0, acc_data_o 0, res_valid_o 0, res_data_o 0, res_id_o 0, res_beats_o 0, busy_o 0, err_o 0.
- Reset mid-frame aborts the frame immediately. No result is produced and the accumulator is left as-is; the next frame clears it.
- Request seen in IDLE at cycle 0: CLEAR at cycle 1, first ready at cycle 2.
- N back-to-back beats: last beat at cycle N+1, DRAIN at N+2, res_valid_o from N+3.
- Minimum frame-to-frame turnaround: 4 cycles plus N, with res_ready_i tied high.
- A single-beat frame (valid & last in the first STREAM cycle) is legal: res_beats_o=1.
- res_ready_i high on the first RESULT cycle gives a 1-cycle res_valid_o pulse, and IDLE arbitrates on the next cycle.
- With NREQ=4, ptr=3 and requesters 0 and 2 valid, the grant is 0 (wrap).

## Test plan

- Single requester 1, 4 beats 1,2,3,4 back-to-back → acc_clear_o at cycle 1, res_valid_o at cycle 7, res_data_o=10, res_id_o=1, res_beats_o=4.
- All 4 requesters valid continuously with 2-beat frames → grants in order 0,1,2,3,0; exactly one ready bit high at a time; each result equals its own requester's sum.
- Requester 0 frame of beats 5, bubble, bubble, 7(last) → 2 beats counted, sum 12, res_beats_o=2.
- res_ready_i held low 10 cycles in RESULT → res_* stable, no ready to any requester, busy_o=1; on release, return to IDLE the next cycle.
- Beat data 2^512-1 then 2 → res_data_o=1 (wrap); 300-beat frame with LEN_W=8 → res_beats_o=255.
- rst_i pulsed at the 2nd beat of a 4-beat frame → all outputs at reset values next cycle; the following frame's sum excludes aborted beats; force acc_valid_i low in DRAIN → err_o=1 sticky until reset.
